// File: rtl/bpred_update_sched.sv
// Branch-predictor update scheduler: queues resolved-branch updates, applies
// 2-bit saturating-counter arithmetic, and arbitrates the table write port with fetch.
`timescale 1ns/1ps

module bpred_update_sched #(
    parameter int IDX_W     = 8,
    parameter int DEPTH     = 4,
    parameter int BIMODAL_W = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      execute_bpredictor_update,
    input  logic [31:0]               execute_bpredictor_PC4,
    input  logic [31:0]               execute_bpredictor_target,
    input  logic                      execute_bpredictor_dir,
    input  logic                      execute_bpredictor_miss,
    input  logic [BIMODAL_W-1:0]      execute_bpredictor_bimodal,
    input  logic                      fetch_lookup_req,
    output logic                      sched_fetch_stall,
    output logic                      sched_busy,
    output logic                      sched_tbl_wren,
    output logic                      sched_btb_wren,
    output logic [IDX_W-1:0]          sched_tbl_addr,
    output logic [BIMODAL_W-1:0]      sched_bimodal_w,
    output logic [29:0]               sched_btb_w,
    output logic [$clog2(DEPTH):0]    sched_count,
    output logic                      sched_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]          pc4;
        logic [31:0]          target;
        logic                 dir;
        logic                 miss;
        logic [BIMODAL_W-1:0] bimodal;
    } entry_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q;
    logic                 busy_q;
    logic                 wren_q;
    logic                 btb_wren_q;
    logic [IDX_W-1:0]     addr_q;
    logic [BIMODAL_W-1:0] bim_q;
    logic [29:0]          btb_q;

    entry_t               fifo_q [DEPTH];
    entry_t               push_entry;
    entry_t               head;

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [31:0]          head_pc;
    logic [IDX_W-1:0]     head_idx;
    logic [1:0]           ctr;
    logic [1:0]           ctr_new;
    logic [BIMODAL_W-1:0] init_pattern;
    logic                 unused_bits;

    // Every 2-bit counter field starts weakly not-taken (01).
    genvar gi;
    generate
        for (gi = 0; gi < BIMODAL_W; gi++) begin : g_init
            assign init_pattern[gi] = ((gi % 2) == 0) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign push_entry = '{
        pc4:     execute_bpredictor_PC4,
        target:  execute_bpredictor_target,
        dir:     execute_bpredictor_dir,
        miss:    execute_bpredictor_miss,
        bimodal: execute_bpredictor_bimodal
    };

    // Fetch owns the port unless the queue is full; a full queue forces a drain.
    assign full = (count_q == FULL_CNT);
    assign pop  = (state_q == ST_RUN) && (count_q != '0) && (!fetch_lookup_req || full);
    assign push = execute_bpredictor_update && (!full || pop);
    assign drop = execute_bpredictor_update && full && !pop;

    assign head     = fifo_q[rd_ptr_q];
    assign head_pc  = head.pc4 - 32'd4;
    assign head_idx = head_pc[IDX_W+1:2];
    assign ctr      = head.bimodal[1:0];

    always_comb begin
        ctr_new = ctr;
        if (head.dir) begin
            if (ctr != 2'b11) ctr_new = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) ctr_new = ctr - 2'b01;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            wren_q     <= 1'b0;
            btb_wren_q <= 1'b0;
            addr_q     <= '0;
            bim_q      <= '0;
            btb_q      <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (drop) overflow_q <= 1'b1;
            // Busy lags the state by one cycle so it drops after the last sweep write is visible.
            busy_q <= (state_q == ST_INIT);
            case (state_q)
                ST_INIT: begin
                    wren_q     <= 1'b1;
                    btb_wren_q <= 1'b1;
                    addr_q     <= idx_q;
                    bim_q      <= init_pattern;
                    btb_q      <= '0;
                    idx_q      <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    wren_q     <= pop;
                    btb_wren_q <= pop && head.dir;
                    if (pop) begin
                        addr_q <= head_idx;
                        bim_q  <= {head.bimodal[BIMODAL_W-1:2], ctr_new};
                        btb_q  <= head.target[31:2];
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign sched_fetch_stall = busy_q || ((state_q == ST_RUN) && fetch_lookup_req && full);
    assign sched_busy        = busy_q;
    assign sched_tbl_wren    = wren_q;
    assign sched_btb_wren    = btb_wren_q;
    assign sched_tbl_addr    = addr_q;
    assign sched_bimodal_w   = bim_q;
    assign sched_btb_w       = btb_q;
    assign sched_count       = count_q;
    assign sched_overflow    = overflow_q;

    // Address bits outside the index and the stored mispredict flag are carried but not consumed.
    assign unused_bits = ^{head_pc[31:IDX_W+2], head_pc[1:0], head.miss, head.target[1:0]};

endmodule

// File: tb/tb_bpred_update_sched.sv
// Randomized bench for bpred_update_sched with a queue-based reference model
// plus directed scenarios carrying literal expectations.
`timescale 1ns/1ps

module tb_bpred_update_sched;

    localparam int IDX_W = 8;
    localparam int DEPTH = 4;
    localparam int BW    = 12;
    localparam int NENT  = 1 << IDX_W;

    logic             clk;
    logic             reset;
    logic             execute_bpredictor_update;
    logic [31:0]      execute_bpredictor_PC4;
    logic [31:0]      execute_bpredictor_target;
    logic             execute_bpredictor_dir;
    logic             execute_bpredictor_miss;
    logic [BW-1:0]    execute_bpredictor_bimodal;
    logic             fetch_lookup_req;
    logic             sched_fetch_stall;
    logic             sched_busy;
    logic             sched_tbl_wren;
    logic             sched_btb_wren;
    logic [IDX_W-1:0] sched_tbl_addr;
    logic [BW-1:0]    sched_bimodal_w;
    logic [29:0]      sched_btb_w;
    logic [2:0]       sched_count;
    logic             sched_overflow;

    bpred_update_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH), .BIMODAL_W(BW)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .execute_bpredictor_update  (execute_bpredictor_update),
        .execute_bpredictor_PC4     (execute_bpredictor_PC4),
        .execute_bpredictor_target  (execute_bpredictor_target),
        .execute_bpredictor_dir     (execute_bpredictor_dir),
        .execute_bpredictor_miss    (execute_bpredictor_miss),
        .execute_bpredictor_bimodal (execute_bpredictor_bimodal),
        .fetch_lookup_req           (fetch_lookup_req),
        .sched_fetch_stall          (sched_fetch_stall),
        .sched_busy                 (sched_busy),
        .sched_tbl_wren             (sched_tbl_wren),
        .sched_btb_wren             (sched_btb_wren),
        .sched_tbl_addr             (sched_tbl_addr),
        .sched_bimodal_w            (sched_bimodal_w),
        .sched_btb_w                (sched_btb_w),
        .sched_count                (sched_count),
        .sched_overflow             (sched_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] tgt;
        logic        dir;
        logic [11:0] bim;
    } upd_t;

    upd_t mq[$];
    upd_t m_last;
    upd_t m_cur;
    int   m_k;          // cycles since the last reset edge
    bit   m_pop;        // a pop happened in the previous cycle
    bit   m_ovf;
    bit   m_do_pop;
    bit   model_valid = 0;

    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic d);
        int v;
        v = c;
        if (d) v = (v < 3) ? v + 1 : 3;
        else   v = (v > 0) ? v - 1 : 0;
        return v[1:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                m_ovf = 0;
                m_k = 0;
                m_pop = 0;
                model_valid = 1;
            end else if (model_valid) begin
                m_do_pop = (m_k >= NENT) && (mq.size() > 0) &&
                           (!fetch_lookup_req || mq.size() == DEPTH);
                m_pop = m_do_pop;
                if (m_do_pop) m_last = mq.pop_front();
                if (execute_bpredictor_update) begin
                    m_cur.pc4 = execute_bpredictor_PC4;
                    m_cur.tgt = execute_bpredictor_target;
                    m_cur.dir = execute_bpredictor_dir;
                    m_cur.bim = execute_bpredictor_bimodal;
                    if (mq.size() < DEPTH) mq.push_back(m_cur);
                    else m_ovf = 1;
                end
                m_k++;
            end
        end
    end

    initial begin
        bit          init_w;
        bit          exp_stall;
        logic [31:0] pcm;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                init_w    = (m_k >= 1) && (m_k <= NENT);
                exp_stall = (m_k <= NENT) ||
                            (fetch_lookup_req && mq.size() == DEPTH);
                chk("m_busy",  sched_busy, m_k <= NENT);
                chk("m_stall", sched_fetch_stall, exp_stall);
                chk("m_count", sched_count, mq.size());
                chk("m_ovf",   sched_overflow, m_ovf);
                chk("m_wren",  sched_tbl_wren, init_w || m_pop);
                if (init_w) begin
                    chk("m_init_addr", sched_tbl_addr, m_k - 1);
                    chk("m_init_bim",  sched_bimodal_w, 12'h555);
                    chk("m_init_btb",  sched_btb_w, 0);
                    chk("m_init_bwen", sched_btb_wren, 1);
                end else if (m_pop) begin
                    pcm = (m_last.pc4 - 32'd4) >> 2;
                    chk("m_addr", sched_tbl_addr, pcm % NENT);
                    chk("m_bim",  sched_bimodal_w,
                        {m_last.bim[11:2], next_ctr(m_last.bim[1:0], m_last.dir)});
                    chk("m_btb",  sched_btb_w, m_last.tgt >> 2);
                    chk("m_bwen", sched_btb_wren, m_last.dir);
                end else begin
                    chk("m_bwen_idle", sched_btb_wren, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] pc4, input logic [31:0] tgt,
                       input logic d, input logic [11:0] b);
        execute_bpredictor_update  = 1'b1;
        execute_bpredictor_PC4     = pc4;
        execute_bpredictor_target  = tgt;
        execute_bpredictor_dir     = d;
        execute_bpredictor_miss    = 1'($urandom_range(0, 1));
        execute_bpredictor_bimodal = b;
    endtask

    task automatic idle();
        execute_bpredictor_update = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        fetch_lookup_req = 1'b0;
        execute_bpredictor_update = 1'b0;
        execute_bpredictor_PC4 = '0;
        execute_bpredictor_target = '0;
        execute_bpredictor_dir = 1'b0;
        execute_bpredictor_miss = 1'b0;
        execute_bpredictor_bimodal = '0;

        // Reset state
        repeat (3) step();
        look();
        chk("rst_busy",  sched_busy, 1);
        chk("rst_stall", sched_fetch_stall, 1);
        chk("rst_wren",  sched_tbl_wren, 0);
        chk("rst_bwen",  sched_btb_wren, 0);
        chk("rst_addr",  sched_tbl_addr, 0);
        chk("rst_bim",   sched_bimodal_w, 0);
        chk("rst_count", sched_count, 0);
        chk("rst_ovf",   sched_overflow, 0);

        // Sweep: writes in cycles 1..256, busy low in 257
        reset = 1'b1;
        step();
        look();
        chk("sw_first_wren", sched_tbl_wren, 1);
        chk("sw_first_addr", sched_tbl_addr, 0);
        chk("sw_first_bim",  sched_bimodal_w, 12'h555);
        repeat (NENT - 1) step();
        look();
        chk("sw_last_addr", sched_tbl_addr, 8'hFF);
        chk("sw_last_busy", sched_busy, 1);
        step();
        look();
        chk("sw_done_busy",  sched_busy, 0);
        chk("sw_done_stall", sched_fetch_stall, 0);
        chk("sw_done_wren",  sched_tbl_wren, 0);

        // Taken update saturates at 3
        step(); upd(32'd128, 32'h40, 1'b1, 12'h003);
        step(); idle();
        step(); look();
        chk("tk_wren", sched_tbl_wren, 1);
        chk("tk_addr", sched_tbl_addr, 31);
        chk("tk_bim",  sched_bimodal_w, 12'h003);
        chk("tk_bwen", sched_btb_wren, 1);
        chk("tk_btb",  sched_btb_w, 30'h10);

        // Not-taken saturates at 0, then decrements 2 -> 1
        step(); upd(32'h200, 32'h1234, 1'b0, 12'hAA0);
        step(); idle();
        step(); look();
        chk("nt0_bim",  sched_bimodal_w, 12'hAA0);
        chk("nt0_bwen", sched_btb_wren, 0);
        chk("nt0_wren", sched_tbl_wren, 1);
        step(); upd(32'h204, 32'h1234, 1'b0, 12'hAA2);
        step(); idle();
        step(); look();
        chk("nt2_bim",  sched_bimodal_w, 12'hAA1);
        chk("nt2_addr", sched_tbl_addr, 8'h80);
        repeat (2) step();

        // Fetch priority: fill while fetch holds the port
        fetch_lookup_req = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            upd($urandom, $urandom, 1'($urandom_range(0, 1)), 12'($urandom));
            look();
            chk("fp_stall", sched_fetch_stall, 0);
            chk("fp_wren",  sched_tbl_wren, 0);
        end
        step();
        upd(32'h300, 32'h5000, 1'b1, 12'h001);
        look();
        chk("fp_full_count", sched_count, 4);
        chk("fp_full_stall", sched_fetch_stall, 1);
        step(); idle(); look();
        chk("fp_after_count", sched_count, 4);
        chk("fp_after_wren",  sched_tbl_wren, 1);
        chk("fp_after_ovf",   sched_overflow, 0);
        fetch_lookup_req = 1'b0;
        repeat (6) step();

        // Overflow during the sweep, then in-order drain
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            upd(32'h1000 + 32'(4 * j) + 32'd4, 32'h8000 + 32'(16 * j), 1'b1, 12'h001);
            step();
        end
        idle();
        look();
        chk("ov_count", sched_count, 4);
        chk("ov_flag",  sched_overflow, 1);
        repeat (NENT - 5) step();
        look();
        chk("ov_busy_256", sched_busy, 1);
        for (int j = 0; j < 4; j++) begin
            step(); look();
            chk("ov_drain_wren", sched_tbl_wren, 1);
            chk("ov_drain_addr", sched_tbl_addr, j);
        end

        // Randomized traffic with rare resets
        for (int c = 0; c < 1500; c++) begin
            step();
            reset = ($urandom_range(0, 399) != 0);
            fetch_lookup_req = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 45)
                upd($urandom, $urandom, 1'($urandom_range(0, 1)), 12'($urandom));
            else
                idle();
        end

        // Reset mid-RUN with three queued updates
        reset = 1'b1;
        fetch_lookup_req = 1'b0;
        idle();
        repeat (NENT + 20) step();
        fetch_lookup_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            upd($urandom, $urandom, 1'b1, 12'($urandom));
        end
        step(); idle(); look();
        chk("mr_pre_count", sched_count, 3);
        reset = 1'b0;
        step(); look();
        chk("mr_count", sched_count, 0);
        chk("mr_ovf",   sched_overflow, 0);
        chk("mr_wren",  sched_tbl_wren, 0);
        chk("mr_busy",  sched_busy, 1);
        reset = 1'b1;
        fetch_lookup_req = 1'b0;
        step(); look();
        chk("mr_sweep_wren", sched_tbl_wren, 1);
        chk("mr_sweep_addr", sched_tbl_addr, 0);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
